// File: rtl/ball_motion_ctrl_if.sv
// ball_motion_ctrl_if: scan-position / collision inputs and ball state outputs.
// Ports (master = video/collision side, slave = ball_motion_ctrl):
//   x_pixel, y_pixel, collision_detected -> slave; is_hit_area, ball_x, ball_y,
//   hit_pulse, hit_count, cooldown_active -> master.
interface ball_motion_ctrl_if;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       collision_detected;
  logic       is_hit_area;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       hit_pulse;
  logic [7:0] hit_count;
  logic       cooldown_active;

  modport master (
    output x_pixel, y_pixel, collision_detected,
    input  is_hit_area, ball_x, ball_y, hit_pulse, hit_count, cooldown_active
  );

  modport slave (
    input  x_pixel, y_pixel, collision_detected,
    output is_hit_area, ball_x, ball_y, hit_pulse, hit_count, cooldown_active
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: bouncing-ball position, direction, hit scoring and hit cooldown.
// Ports: clk_25MHz (pixel clock), reset (sync, active-high), io (slave modport):
//   scan position + collision flag in; hit-area flag, ball position, hit strobe/score, cooldown flag out.
// Latency: state moves once per frame, on the cycle the scan sits at (0, SCREEN_H); is_hit_area is combinational.
module ball_motion_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int BALL_SIZE       = 20,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int X_INIT          = 310,
  parameter int Y_INIT          = 230
) (
  input logic               clk_25MHz,
  input logic               reset,
  ball_motion_ctrl_if.slave io
);

  typedef enum logic {MOVE = 1'b0, COOLDOWN = 1'b1} state_t;

  localparam int X_MAX = SCREEN_W - BALL_SIZE;
  localparam int Y_MAX = SCREEN_H - BALL_SIZE;
  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_latch_q, hit_latch_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic [9:0]         ball_x_q, ball_x_d;
  logic [9:0]         ball_y_q, ball_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;

  logic               frame_tick;
  logic               coll_move;
  logic               hit;
  logic               dir_x_h, dir_y_h;
  logic signed [10:0] cand_x, cand_y;
  logic [10:0]        x_end, y_end;

  // Frame boundary: first pixel of the first blanking line below active video.
  assign frame_tick = (io.x_pixel == 10'd0) && (io.y_pixel == 10'(SCREEN_H));

  // 11-bit end coordinates so ball_x + BALL_SIZE cannot wrap.
  assign x_end = {1'b0, ball_x_q} + 11'(BALL_SIZE);
  assign y_end = {1'b0, ball_y_q} + 11'(BALL_SIZE);

  assign io.is_hit_area = (io.x_pixel >= ball_x_q) && ({1'b0, io.x_pixel} < x_end) &&
                          (io.y_pixel >= ball_y_q) && ({1'b0, io.y_pixel} < y_end);

  assign io.ball_x          = ball_x_q;
  assign io.ball_y          = ball_y_q;
  assign io.hit_pulse       = hit_pulse_q;
  assign io.hit_count       = hit_count_q;
  assign io.cooldown_active = (state_q == COOLDOWN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_latch_d = hit_latch_q;
    hit_pulse_d = 1'b0;
    hit_count_d = hit_count_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    dir_x_h     = dir_x_q;
    dir_y_h     = dir_y_q;
    cand_x      = '0;
    cand_y      = '0;

    // Collisions only count while moving; in COOLDOWN they never reach the latch.
    coll_move = io.collision_detected && (state_q == MOVE);
    // A collision on the tick cycle itself is consumed by that same tick.
    hit       = hit_latch_q || coll_move;

    if (coll_move) begin
      hit_latch_d = 1'b1;
    end

    if (frame_tick) begin
      hit_latch_d = 1'b0;

      case (state_q)
        MOVE: begin
          if (hit) begin
            dir_x_h     = ~dir_x_q;
            dir_y_h     = ~dir_y_q;
            hit_pulse_d = 1'b1;
            if (hit_count_q != 8'hFF) begin
              hit_count_d = hit_count_q + 8'd1;
            end
            cnt_d   = CNT_W'(COOLDOWN_FRAMES);
            state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          // Leave on the tick that brings the counter to zero.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = MOVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = MOVE;
      endcase

      // Step uses the post-hit direction; walls may then reverse it again.
      cand_x = dir_x_h ? $signed({1'b0, ball_x_q}) + $signed(11'(SPEED))
                       : $signed({1'b0, ball_x_q}) - $signed(11'(SPEED));
      cand_y = dir_y_h ? $signed({1'b0, ball_y_q}) + $signed(11'(SPEED))
                       : $signed({1'b0, ball_y_q}) - $signed(11'(SPEED));

      dir_x_d  = dir_x_h;
      ball_x_d = cand_x[9:0];
      if (cand_x < 11'sd0) begin
        ball_x_d = 10'd0;
        dir_x_d  = 1'b1;
      end else if (cand_x > $signed(11'(X_MAX))) begin
        ball_x_d = 10'(X_MAX);
        dir_x_d  = 1'b0;
      end

      dir_y_d  = dir_y_h;
      ball_y_d = cand_y[9:0];
      if (cand_y < 11'sd0) begin
        ball_y_d = 10'd0;
        dir_y_d  = 1'b1;
      end else if (cand_y > $signed(11'(Y_MAX))) begin
        ball_y_d = 10'(Y_MAX);
        dir_y_d  = 1'b0;
      end
    end
  end

  // Reset has priority over any tick or pending hit in the same cycle.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q     <= MOVE;
      cnt_q       <= '0;
      hit_latch_q <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= 8'd0;
      ball_x_q    <= 10'(X_INIT);
      ball_y_q    <= 10'(Y_INIT);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_latch_q <= hit_latch_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
    end
  end

endmodule
